// File: rtl/d_ext_ctrl.sv
// F/D stage register for the P7 core: captures the fetched instruction, decodes the
// immediate-extension mode and raises reserved-instruction on illegal encodings.
module d_ext_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] F_instr,
    input  logic [31:0] F_pc,
    input  logic [4:0]  F_excCode,
    input  logic        F_BD,
    input  logic        D_stall,
    input  logic        D_flush,
    input  logic        Req,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic [15:0] D_imm16,
    output logic [1:0]  D_EXTOp,
    output logic [4:0]  D_excCode,
    output logic        D_BD,
    output logic        D_valid
);
    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] PC_EXC   = 32'h0000_4180;
    localparam logic [4:0]  EXC_RI   = 5'd10;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_COP0    = 6'b010000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] OP_SH      = 6'b101001;
    localparam logic [5:0] OP_SW      = 6'b101011;

    logic [31:0] instr, pc;
    logic [4:0]  exc_f;
    logic        bd, valid;

    // Req outranks stall so an exception can never be swallowed by a held stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr <= '0;
            pc    <= PC_RESET;
            exc_f <= '0;
            bd    <= 1'b0;
            valid <= 1'b0;
        end else if (Req) begin
            instr <= '0;
            pc    <= PC_EXC;
            exc_f <= '0;
            bd    <= 1'b0;
            valid <= 1'b0;
        end else if (D_stall) begin
            instr <= instr;
            pc    <= pc;
            exc_f <= exc_f;
            bd    <= bd;
            valid <= valid;
        end else if (D_flush) begin
            instr <= '0;
            pc    <= F_pc;
            exc_f <= '0;
            bd    <= 1'b0;
            valid <= 1'b0;
        end else begin
            instr <= F_instr;
            pc    <= F_pc;
            exc_f <= F_excCode;
            bd    <= F_BD;
            valid <= 1'b1;
        end
    end

    logic [5:0] op, fn;
    logic [4:0] rs;
    logic       legal;

    assign op = instr[31:26];
    assign rs = instr[25:21];
    assign fn = instr[5:0];

    always_comb begin
        D_EXTOp = EXT_ZERO;
        case (op)
            OP_LUI:  D_EXTOp = EXT_LUI;
            OP_ADDI, OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW,
            OP_BEQ, OP_BNE: D_EXTOp = EXT_SIGN;
            default: D_EXTOp = EXT_ZERO;
        endcase
    end

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_SPECIAL: begin
                case (fn)
                    6'b100000, 6'b100010, 6'b100100, 6'b100101,
                    6'b101010, 6'b101011, 6'b011000, 6'b011001,
                    6'b011010, 6'b011011, 6'b010000, 6'b010010,
                    6'b010001, 6'b010011, 6'b001000, 6'b001100: legal = 1'b1;
                    default: legal = 1'b0;
                endcase
            end
            OP_COP0: legal = (rs == 5'b00000) || (rs == 5'b00100) ||
                             (rs == 5'b10000 && fn == 6'b011000);
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI,
            OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        // A nop encodes as SPECIAL/sll, which isn't in the table above.
        if (instr == 32'd0) legal = 1'b1;
    end

    always_comb begin
        D_excCode = 5'd0;
        if (exc_f != 5'd0)
            D_excCode = exc_f;
        else if (valid && !legal)
            D_excCode = EXC_RI;
    end

    assign D_instr = instr;
    assign D_pc    = pc;
    assign D_imm16 = instr[15:0];
    assign D_BD    = bd;
    assign D_valid = valid;
endmodule

// File: tb/tb_d_ext_ctrl.sv
// Directed bench for d_ext_ctrl: a table-driven reference model checked every cycle,
// plus hand-computed literal expectations at the interesting points.
module tb_d_ext_ctrl;
    logic        clk, reset;
    logic [31:0] F_instr, F_pc;
    logic [4:0]  F_excCode;
    logic        F_BD, D_stall, D_flush, Req;
    logic [31:0] D_instr, D_pc;
    logic [15:0] D_imm16;
    logic [1:0]  D_EXTOp;
    logic [4:0]  D_excCode;
    logic        D_BD, D_valid;

    int n_cmp = 0;
    int n_err = 0;

    d_ext_ctrl dut (
        .clk(clk), .reset(reset), .F_instr(F_instr), .F_pc(F_pc),
        .F_excCode(F_excCode), .F_BD(F_BD), .D_stall(D_stall), .D_flush(D_flush),
        .Req(Req), .D_instr(D_instr), .D_pc(D_pc), .D_imm16(D_imm16),
        .D_EXTOp(D_EXTOp), .D_excCode(D_excCode), .D_BD(D_BD), .D_valid(D_valid)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Opcode/function tables straight from the instruction list.
    logic [5:0] sign_ops[9]  = '{6'o10, 6'o40, 6'o41, 6'o43, 6'o50, 6'o51, 6'o53, 6'o04, 6'o05};
    logic [5:0] other_ops[5] = '{6'o17, 6'o14, 6'o15, 6'o02, 6'o03};
    logic [5:0] r_fns[16]    = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h18, 6'h19,
                                 6'h1A, 6'h1B, 6'h10, 6'h12, 6'h11, 6'h13, 6'h08, 6'h0C};

    function automatic logic [1:0] m_ext(input logic [31:0] ins);
        if (ins[31:26] == 6'o17) return 2'd2;
        foreach (sign_ops[i]) if (ins[31:26] == sign_ops[i]) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit m_legal(input logic [31:0] ins);
        if (ins == 0) return 1;
        foreach (sign_ops[i])  if (ins[31:26] == sign_ops[i])  return 1;
        foreach (other_ops[i]) if (ins[31:26] == other_ops[i]) return 1;
        if (ins[31:26] == 0) begin
            foreach (r_fns[i]) if (ins[5:0] == r_fns[i]) return 1;
            return 0;
        end
        if (ins[31:26] == 6'b010000)
            return ins[25:21] == 5'd0 || ins[25:21] == 5'd4 ||
                   (ins[25:21] == 5'd16 && ins[5:0] == 6'h18);
        return 0;
    endfunction

    // Model: the stage content as a single record, replaced whole on each edge.
    typedef struct packed {
        logic [31:0] instr, pc;
        logic [4:0]  exc;
        logic        bd, valid;
    } stage_t;
    stage_t m;

    always @(posedge clk or negedge reset) begin
        if (!reset)      m <= '{32'd0, 32'h3000, 5'd0, 1'b0, 1'b0};
        else if (Req)    m <= '{32'd0, 32'h4180, 5'd0, 1'b0, 1'b0};
        else if (D_stall) m <= m;
        else if (D_flush) m <= '{32'd0, F_pc, 5'd0, 1'b0, 1'b0};
        else             m <= '{F_instr, F_pc, F_excCode, F_BD, 1'b1};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [4:0] e;
        e = (m.exc != 0) ? m.exc : ((m.valid && !m_legal(m.instr)) ? 5'd10 : 5'd0);
        chk("instr", D_instr, m.instr);
        chk("pc", D_pc, m.pc);
        chk("imm16", {16'd0, D_imm16}, {16'd0, m.instr[15:0]});
        chk("extop", {30'd0, D_EXTOp}, {30'd0, m_ext(m.instr)});
        chk("exc", {27'd0, D_excCode}, {27'd0, e});
        chk("bd", {31'd0, D_BD}, {31'd0, m.bd});
        chk("valid", {31'd0, D_valid}, {31'd0, m.valid});
    end

    task automatic drive(input logic [31:0] ins, input logic [31:0] p,
                         input logic [4:0] ex = 0, input logic b = 0,
                         input logic st = 0, input logic fl = 0, input logic rq = 0);
        F_instr = ins; F_pc = p; F_excCode = ex; F_BD = b;
        D_stall = st; D_flush = fl; Req = rq;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 0;
        F_instr = 32'hDEADBEEF; F_pc = 32'h1234; F_excCode = 5'd4; F_BD = 1;
        D_stall = 0; D_flush = 0; Req = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", D_pc, 32'h3000);
        chk("rst_instr", D_instr, 32'd0);
        chk("rst_valid", {31'd0, D_valid}, 32'd0);
        chk("rst_exc", {27'd0, D_excCode}, 32'd0);
        reset = 1;

        drive(32'h3C011234, 32'h3000);
        chk("lui_ext", {30'd0, D_EXTOp}, 32'd2);
        chk("lui_imm", {16'd0, D_imm16}, 32'h1234);
        chk("lui_valid", {31'd0, D_valid}, 32'd1);
        drive(32'h3422FFFF, 32'h3004);
        chk("ori_ext", {30'd0, D_EXTOp}, 32'd0);
        drive(32'h8C23FFFC, 32'h3008);
        chk("lw_ext", {30'd0, D_EXTOp}, 32'd1);
        chk("lw_imm", {16'd0, D_imm16}, 32'hFFFC);
        drive(32'h10220003, 32'h300C);
        chk("beq_ext", {30'd0, D_EXTOp}, 32'd1);
        drive(32'h00221820, 32'h3010);
        chk("add_ext", {30'd0, D_EXTOp}, 32'd0);
        chk("add_exc", {27'd0, D_excCode}, 32'd0);

        // Stall holds across three cycles while F keeps moving.
        drive(32'h2001FFFF, 32'h3014);
        for (int i = 0; i < 3; i++) begin
            drive(32'h3C020000 + i, 32'h3018 + 4 * i, 0, 0, 1);
            chk("stall_instr", D_instr, 32'h2001FFFF);
            chk("stall_pc", D_pc, 32'h3014);
        end
        drive(32'h3C05ABCD, 32'h3024);
        chk("unstall_instr", D_instr, 32'h3C05ABCD);
        // Stall beats flush.
        drive(32'h3C060000, 32'h3028, 0, 0, 1, 1);
        chk("stall_flush", D_instr, 32'h3C05ABCD);

        drive(32'h3C070000, 32'h3010, 0, 0, 0, 1);
        chk("flush_instr", D_instr, 32'd0);
        chk("flush_pc", D_pc, 32'h3010);
        chk("flush_valid", {31'd0, D_valid}, 32'd0);
        drive(32'h3C080001, 32'h3030, 0, 1);
        drive(32'h3C090000, 32'h3034, 0, 1, 1, 0, 1);
        chk("req_pc", D_pc, 32'h4180);
        chk("req_instr", D_instr, 32'd0);
        chk("req_bd", {31'd0, D_BD}, 32'd0);

        drive(32'hFC000000, 32'h4180);
        chk("ri", {27'd0, D_excCode}, 32'd10);
        drive(32'hFC000000, 32'h4184, 5'd4);
        chk("adel_beats_ri", {27'd0, D_excCode}, 32'd4);
        drive(32'h00000001, 32'h4188);
        chk("ri_fn", {27'd0, D_excCode}, 32'd10);
        drive(32'h42000018, 32'h418C);   // eret
        drive(32'h40026000, 32'h4190);   // mfc0
        drive(32'h40200000, 32'h4194);   // cop0 rs=1 is reserved
        chk("ri_cop0", {27'd0, D_excCode}, 32'd10);
        drive(32'h0C000C00, 32'h4198);   // jal

        drive(32'hAC220008, 32'h419C, 0, 1);
        chk("bd_set", {31'd0, D_BD}, 32'd1);
        chk("sw_ext", {30'd0, D_EXTOp}, 32'd1);
        drive(32'h00000000, 32'h41A0, 0, 1, 0, 1);
        chk("bd_flush", {31'd0, D_BD}, 32'd0);

        // Asynchronous reset in the middle of a stall.
        drive(32'h2001FFFF, 32'h41A4);
        drive(32'h2001FFFF, 32'h41A8, 0, 0, 1);
        #2 reset = 0;
        #1;
        chk("async_pc", D_pc, 32'h3000);
        chk("async_valid", {31'd0, D_valid}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1;
        drive(32'h3C0A0001, 32'h3000);
        chk("post_rst", D_instr, 32'h3C0A0001);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
